// File: rtl/lsu.sv
// Load/store unit between EXU and WBU: one AXI4-Lite read or write per accepted instruction.
// Optional misalignment trap selected by macro LSU_MISALIGN_CHECK_EN.
module lsu #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_pre_valid,
  output logic          o_pre_ready,
  output logic          o_post_valid,
  input  logic          i_post_ready,
  input  logic [31:0]   i_lsu_alu_res,
  input  logic [31:0]   i_lsu_wdata,
  input  logic          i_lsu_mem_ren,
  input  logic          i_lsu_mem_wen,
  input  logic [2:0]    i_lsu_funct3,
  output logic [31:0]   o_lsu_rd,
  output logic          o_lsu_fault,
  output logic [AW-1:0] o_araddr,
  output logic          o_arvalid,
  input  logic          i_arready,
  input  logic [DW-1:0] i_rdata,
  input  logic [1:0]    i_rresp,
  input  logic          i_rvalid,
  output logic          o_rready,
  output logic [AW-1:0] o_awaddr,
  output logic          o_awvalid,
  input  logic          i_awready,
  output logic [DW-1:0] o_wdata,
  output logic [3:0]    o_wstrb,
  output logic          o_wvalid,
  input  logic          i_wready,
  input  logic [1:0]    i_bresp,
  input  logic          i_bvalid,
  output logic          o_bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [AW-1:0]  r_addr;
  logic [2:0]     r_funct3;
  logic [DW-1:0]  r_wdata;
  logic [3:0]     r_wstrb;
  logic [31:0]    r_rd;
  logic           r_fault;
  logic           r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready, r_post_valid;

  logic           w_accept, w_misalign, w_aw_ok, w_w_ok;
  logic [3:0]     w_wstrb;
  logic [DW-1:0]  w_wdata;
  logic [DW-1:0]  w_shifted;
  logic [31:0]    w_load;

  assign o_pre_ready = (r_state == S_IDLE);
  assign w_accept    = i_pre_valid & o_pre_ready;

`ifdef LSU_MISALIGN_CHECK_EN
  logic w_half, w_word;
  assign w_half     = (i_lsu_funct3 == 3'b001) | (i_lsu_funct3 == 3'b101);
  assign w_word     = (i_lsu_funct3 == 3'b010);
  assign w_misalign = (i_lsu_mem_ren | i_lsu_mem_wen) &
                      ((w_half & i_lsu_alu_res[0]) | (w_word & (i_lsu_alu_res[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  // Store lanes are replicated so the strobe alone selects the target bytes.
  always_comb begin
    w_wstrb = 4'hF;
    w_wdata = i_lsu_wdata;
    case (i_lsu_funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << i_lsu_alu_res[1:0];
        w_wdata = {4{i_lsu_wdata[7:0]}};
      end
      2'b01: begin
        w_wstrb = 4'b0011 << i_lsu_alu_res[1:0];
        w_wdata = {2{i_lsu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shifted = i_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = w_shifted;
    case (r_funct3)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load = {24'd0, w_shifted[7:0]};
      3'b101:  w_load = {16'd0, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  // A channel counts as done once its valid has dropped or handshakes this cycle.
  assign w_aw_ok = ~r_awvalid | i_awready;
  assign w_w_ok  = ~r_wvalid  | i_wready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misalign)         w_next = S_DONE;
          else if (i_lsu_mem_ren) w_next = S_AR;
          else if (i_lsu_mem_wen) w_next = S_WR;
          else                    w_next = S_DONE;
        end
      end
      S_AR:    if (i_arready)          w_next = S_R;
      S_R:     if (i_rvalid)           w_next = S_DONE;
      S_WR:    if (w_aw_ok && w_w_ok)  w_next = S_B;
      S_B:     if (i_bvalid)           w_next = S_DONE;
      S_DONE:  if (i_post_ready)       w_next = S_IDLE;
      default:                         w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_funct3     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_rd         <= '0;
      r_fault      <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_post_valid <= 1'b0;
    end else begin
      r_arvalid    <= (w_next == S_AR);
      r_rready     <= (w_next == S_R);
      r_bready     <= (w_next == S_B);
      r_post_valid <= (w_next == S_DONE);
      if (w_accept) begin
        r_addr    <= AW'(i_lsu_alu_res);
        r_funct3  <= i_lsu_funct3;
        r_wdata   <= w_wdata;
        r_wstrb   <= w_wstrb;
        r_rd      <= (i_lsu_mem_ren | i_lsu_mem_wen) ? 32'd0 : i_lsu_alu_res;
        r_fault   <= w_misalign;
        r_awvalid <= (w_next == S_WR);
        r_wvalid  <= (w_next == S_WR);
      end else if (r_state == S_WR) begin
        r_awvalid <= r_awvalid & ~i_awready;
        r_wvalid  <= r_wvalid & ~i_wready;
      end
      if (r_state == S_R && i_rvalid) begin
        r_rd    <= w_load;
        r_fault <= (i_rresp != 2'b00);
      end
      if (r_state == S_B && i_bvalid) r_fault <= (i_bresp != 2'b00);
    end
  end

  assign o_araddr     = r_addr;
  assign o_awaddr     = r_addr;
  assign o_wdata      = r_wdata;
  assign o_wstrb      = r_wstrb;
  assign o_arvalid    = r_arvalid;
  assign o_rready     = r_rready;
  assign o_awvalid    = r_awvalid;
  assign o_wvalid     = r_wvalid;
  assign o_bready     = r_bready;
  assign o_post_valid = r_post_valid;
  assign o_lsu_rd     = r_rd;
  assign o_lsu_fault  = r_fault;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed cases plus randomized instructions against an AXI slave model
// with per-channel ready/valid delays; expectations come from a behavioural reference.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_pre_valid, o_pre_ready, o_post_valid, i_post_ready;
  logic [31:0] i_lsu_alu_res, i_lsu_wdata, o_lsu_rd;
  logic        i_lsu_mem_ren, i_lsu_mem_wen, o_lsu_fault;
  logic [2:0]  i_lsu_funct3;
  logic [31:0] o_araddr, i_rdata, o_awaddr, o_wdata;
  logic        o_arvalid, i_arready, i_rvalid, o_rready;
  logic        o_awvalid, i_awready, o_wvalid, i_wready, i_bvalid, o_bready;
  logic [1:0]  i_rresp, i_bresp;
  logic [3:0]  o_wstrb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .i_pre_valid(i_pre_valid), .o_pre_ready(o_pre_ready),
    .o_post_valid(o_post_valid), .i_post_ready(i_post_ready),
    .i_lsu_alu_res(i_lsu_alu_res), .i_lsu_wdata(i_lsu_wdata),
    .i_lsu_mem_ren(i_lsu_mem_ren), .i_lsu_mem_wen(i_lsu_mem_wen),
    .i_lsu_funct3(i_lsu_funct3), .o_lsu_rd(o_lsu_rd), .o_lsu_fault(o_lsu_fault),
    .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    if (f3 == 3'd2) return (a % 4) != 0;
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) != 0;
    return 1'b0;
`else
    return (f3 == 3'd7) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
    logic [31:0] v, x;
    v = d >> (8 * (a % 4));
    case (f3)
      3'd0: begin x = v % 256;   if (x >= 128)   x = x + 32'hFFFF_FF00; end
      3'd1: begin x = v % 65536; if (x >= 32768) x = x + 32'hFFFF_0000; end
      3'd4: x = v % 256;
      3'd5: x = v % 65536;
      default: x = v;
    endcase
    return x;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] s;
    if (f3[1:0] == 2'd0)      s = 32'd1 << (a % 4);
    else if (f3[1:0] == 2'd1) s = (32'd3 << (a % 4)) % 16;
    else                      s = 32'd15;
    return s[3:0];
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] rs2);
    if (f3[1:0] == 2'd0) return (rs2 % 256) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (rs2 % 65536) * 32'h0001_0001;
    return rs2;
  endfunction

  task automatic idle_inputs();
    i_arready = 0; i_rvalid = 0; i_awready = 0; i_wready = 0; i_bvalid = 0;
    i_post_ready = 0;
  endtask

  // Called at a negedge while the DUT idles; returns at the negedge after the WBU handshake.
  task automatic run_instr(input bit ren, input bit wen, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2,
                           input logic [31:0] rdata, input logic [1:0] resp,
                           input int arlat, input int rlat, input int awlat,
                           input int wlat, input int blat, input int plat);
    bit is_ld, is_st, mis, done, pv_seen, r_sent, b_sent;
    logic [31:0] exp_rd;
    bit exp_fault;
    int exp_lat, cyc, ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, pv_cnt;
    int ar_hs, aw_hs, w_hs;
    is_ld = ren;
    is_st = wen && !ren;
    mis   = (is_ld || is_st) && misaligned(f3, addr);
    if (mis) begin
      exp_rd = 0; exp_fault = 1; exp_lat = 1;
    end else if (is_ld) begin
      exp_rd = load_value(f3, addr, rdata); exp_fault = (resp != 0); exp_lat = 3 + arlat + rlat;
    end else if (is_st) begin
      exp_rd = 0; exp_fault = (resp != 0);
      exp_lat = 3 + ((awlat > wlat) ? awlat : wlat) + blat;
    end else begin
      exp_rd = addr; exp_fault = 0; exp_lat = 1;
    end

    check("gap_post_valid", {31'd0, o_post_valid}, 32'd0);
    check("idle_pre_ready", {31'd0, o_pre_ready}, 32'd1);
    i_pre_valid = 1; i_lsu_mem_ren = ren; i_lsu_mem_wen = wen; i_lsu_funct3 = f3;
    i_lsu_alu_res = addr; i_lsu_wdata = rs2;
    @(negedge clk);
    i_pre_valid = 0; i_lsu_alu_res = $urandom; i_lsu_wdata = $urandom;
    i_lsu_funct3 = 3'($urandom); i_lsu_mem_ren = 1'($urandom); i_lsu_mem_wen = 1'($urandom);
    i_rdata = rdata; i_rresp = is_ld ? resp : 2'd0; i_bresp = is_st ? resp : 2'd0;

    done = 0; pv_seen = 0; r_sent = 0; b_sent = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; pv_cnt = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0;
    cyc = 1;
    while (!done && cyc < 80) begin
      i_arready = o_arvalid && (ar_cnt >= arlat);
      if (o_arvalid) begin
        check("araddr_stable", o_araddr, addr);
        if (i_arready) ar_hs++;
        ar_cnt++;
      end
      i_rvalid = o_rready && !r_sent && (r_cnt >= rlat);
      if (o_rready) begin r_cnt++; if (i_rvalid) r_sent = 1; end
      i_awready = o_awvalid && (aw_cnt >= awlat);
      if (o_awvalid) begin
        check("awaddr_stable", o_awaddr, addr);
        if (i_awready) aw_hs++;
        aw_cnt++;
      end
      i_wready = o_wvalid && (w_cnt >= wlat);
      if (o_wvalid) begin
        check("wdata_stable", o_wdata, store_data(f3, rs2));
        check("wstrb_stable", {28'd0, o_wstrb}, {28'd0, store_strb(f3, addr)});
        if (i_wready) w_hs++;
        w_cnt++;
      end
      i_bvalid = o_bready && !b_sent && (aw_hs == 1) && (w_hs == 1) && (b_cnt >= blat);
      if (o_bready) begin b_cnt++; if (i_bvalid) b_sent = 1; end
      if (o_post_valid) begin
        if (!pv_seen) begin
          check("post_latency", cyc, exp_lat);
          pv_seen = 1;
        end
        check("rd", o_lsu_rd, exp_rd);
        check("fault", {31'd0, o_lsu_fault}, {31'd0, exp_fault});
        i_post_ready = (pv_cnt >= plat);
        if (i_post_ready) done = 1;
        pv_cnt++;
      end else begin
        i_post_ready = 0;
      end
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    if (!done) check("instr_timeout", 32'(cyc), 32'(exp_lat));
    check("ar_handshakes", ar_hs, (is_ld && !mis) ? 1 : 0);
    check("aw_handshakes", aw_hs, (is_st && !mis) ? 1 : 0);
    check("w_handshakes", w_hs, (is_st && !mis) ? 1 : 0);
    check("r_beats", {31'd0, r_sent}, (is_ld && !mis) ? 1 : 0);
    check("b_beats", {31'd0, b_sent}, (is_st && !mis) ? 1 : 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_pre_ready"}, {31'd0, o_pre_ready}, 32'd1);
    check({tag, "_post_valid"}, {31'd0, o_post_valid}, 32'd0);
    check({tag, "_arvalid"}, {31'd0, o_arvalid}, 32'd0);
    check({tag, "_rready"}, {31'd0, o_rready}, 32'd0);
    check({tag, "_awvalid"}, {31'd0, o_awvalid}, 32'd0);
    check({tag, "_wvalid"}, {31'd0, o_wvalid}, 32'd0);
    check({tag, "_bready"}, {31'd0, o_bready}, 32'd0);
  endtask

  initial begin
    rst = 1; i_pre_valid = 0; i_lsu_alu_res = 0; i_lsu_wdata = 0;
    i_lsu_mem_ren = 0; i_lsu_mem_wen = 0; i_lsu_funct3 = 0;
    i_rdata = 0; i_rresp = 0; i_bresp = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_rd", o_lsu_rd, 32'd0);
    check("reset_fault", {31'd0, o_lsu_fault}, 32'd0);
    rst = 0;

    // Directed cases: pass-through, sign/zero-extended byte loads, delayed AW store,
    // load bus error then fault clearing, misaligned word store.
    run_instr(0, 0, 3'd0, 32'h0000_1234, 32'h0, 32'h0, 2'd0, 0, 0, 0, 0, 0, 0);
    run_instr(1, 0, 3'd0, 32'h8000_0003, 32'h0, 32'h80FF_0000, 2'd0, 0, 0, 0, 0, 0, 0);
    run_instr(1, 0, 3'd4, 32'h8000_0003, 32'h0, 32'h80FF_0000, 2'd0, 0, 0, 0, 0, 0, 0);
    run_instr(0, 1, 3'd0, 32'h8000_0000, 32'h0000_0055, 32'h0, 2'd0, 0, 0, 0, 0, 0, 0);
    run_instr(0, 1, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 2'd0, 0, 0, 3, 0, 1, 1);
    run_instr(1, 0, 3'd2, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 2'd2, 1, 2, 0, 0, 0, 0);
    run_instr(0, 0, 3'd0, 32'h0000_0042, 32'h0, 32'h0, 2'd0, 0, 0, 0, 0, 0, 0);
    run_instr(0, 1, 3'd2, 32'h8000_0001, 32'h1122_3344, 32'h0, 2'd0, 0, 0, 0, 0, 0, 0);
    run_instr(1, 1, 3'd5, 32'h8000_0006, 32'h0, 32'hC3D2_8001, 2'd0, 0, 0, 0, 0, 0, 2);

    // Reset mid-load while the slave withholds arready.
    i_pre_valid = 1; i_lsu_mem_ren = 1; i_lsu_mem_wen = 0; i_lsu_funct3 = 3'd2;
    i_lsu_alu_res = 32'h8000_0100;
    @(negedge clk);
    i_pre_valid = 0; i_lsu_mem_ren = 0;
    @(negedge clk);
    check("pre_rst_arvalid", {31'd0, o_arvalid}, 32'd1);
    rst = 1;
    @(negedge clk);
    check_quiet("midrst");
    rst = 0;
    run_instr(1, 0, 3'd2, 32'h8000_0104, 32'h0, 32'h0BAD_F00D, 2'd0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      int kind;
      bit ren, wen;
      logic [2:0] f3;
      logic [1:0] resp;
      kind = int'($urandom_range(0, 9));
      ren  = (kind >= 2 && kind <= 5) || kind == 9;
      wen  = (kind >= 6);
      if (ren) begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 2));
      end
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      run_instr(ren, wen, f3, $urandom, $urandom, $urandom, resp,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the multi-cycle NPC core. It sits between EXU and WBU. It accepts one instruction per handshake from EXU and performs at most one AXI4-Lite data-memory transaction, either a read or a write. It then presents the write-back value to WBU with a valid/ready handshake. Between instructions it drops valid for at least one cycle, because WBU edge-detects it.

## Interface
Parameters:
- AW, default 32, bus address width.
- DW, fixed at 32, data width. Only 32 is supported.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset: synchronous, active-high.
- i_pre_valid, input, 1, EXU has an instruction.
- o_pre_ready, output, 1, LSU can accept an instruction.
- o_post_valid, output, 1, write-back data valid to WBU.
- i_post_ready, input, 1, WBU accepts.
- i_lsu_alu_res, input, 32, effective address, or the pass-through result for non-memory instructions.
- i_lsu_wdata, input, 32, store data (rs2).
- i_lsu_mem_ren, input, 1, load.
- i_lsu_mem_wen, input, 1, store.
- i_lsu_funct3, input, 3, access size and sign.
- o_lsu_rd, output, 32, write-back value.
- o_lsu_fault, output, 1, bus error or misalign flag.
- AXI4-Lite master: araddr[AW], arvalid, arready, rdata[32], rresp[2], rvalid, rready, awaddr[AW], awvalid, awready, wdata[32], wstrb[4], wvalid, wready, bresp[2], bvalid, bready.

## Operation
- FSM states: IDLE, AR, R, WR, B, DONE.
- o_pre_ready is 1 only in IDLE. Inputs are latched on i_pre_valid & o_pre_ready.
- Transitions out of IDLE on accept:
  - mem_ren set: go to AR.
  - mem_wen set: go to WR.
  - Neither set: go to DONE, with o_lsu_rd = i_lsu_alu_res.
  - Both set: treated as a load.
- AR: arvalid = 1 and araddr = latched address (full, unaligned). On arready, go to R.
- R: rready = 1. On rvalid, latch the extracted data and go to DONE.
- Load extraction: sh = addr[1:0]*8, v = rdata >> sh.
  - 000 LB: sign-extend v[7:0].
  - 001 LH: sign-extend v[15:0].
  - 010 LW: v.
  - 100 LBU: zero-extend v[7:0].
  - 101 LHU: zero-extend v[15:0].
  - Other encodings: v.
- WR: awvalid and wvalid assert together. Each drops independently after its own handshake. Go to B once both handshakes are done, including in the same cycle.
- Store strobes and data, with off = addr[1:0]:
  - SB: wstrb = 4'b0001<<off, wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 4'b0011<<off (truncated to 4 bits), wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 4'hF, wdata = rs2.
- B: bready = 1. On bvalid, go to DONE. o_lsu_rd = 0 for stores.
- Fault: rresp or bresp ≠ 0 sets o_lsu_fault = 1 for that instruction. The flag clears on the next accept.
- DONE: o_post_valid = 1, holding o_lsu_rd and o_lsu_fault stable. On i_post_ready, go to IDLE, where o_post_valid = 0.

## Timing
- Reset values:
  - State IDLE, o_pre_ready = 1, o_post_valid = 0.
  - arvalid, rready, awvalid, wvalid, bready = 0.
  - o_lsu_rd = 0, o_lsu_fault = 0.
- A reset mid-transaction abandons it immediately: all valids and readies go low the cycle after rst is sampled.
- Latencies, with accept at cycle 0:
  - Non-memory: o_post_valid at cycle 1.
  - Load, zero-wait slave: AR at cycle 1, R at cycle 2, DONE at cycle 3.
  - Store, zero-wait slave: WR at cycle 1, B at cycle 2, DONE at cycle 3.
- A slave may hold a ready low indefinitely. The LSU keeps valid, address, data and strobe stable until the handshake.
- o_post_valid is low for at least one cycle between consecutive instructions, because DONE→IDLE→accept.
- All outputs are registered except o_pre_ready, which is decoded from state.

## Configuration
- LSU_MISALIGN_CHECK_EN defined:
  - Checks LH/LHU/SH with addr[0] = 1, and LW/SW with addr[1:0] ≠ 0.
  - A failing check issues no bus transaction. The FSM goes IDLE→DONE with o_lsu_fault = 1 and o_lsu_rd = 0.
- LSU_MISALIGN_CHECK_EN undefined:
  - No check. Misaligned accesses go to the bus as described, with strobes truncated.

## Test plan
- Non-memory instruction, alu_res = 0x1234, i_post_ready = 1: o_post_valid at cycle 1 with o_lsu_rd = 0x1234. No AXI valids assert.
- LB at 0x8000_0003, rdata = 0x80FF_0000: o_lsu_rd = 0xFFFF_FF80. With LBU: 0x0000_0080.
- SH at 0x8000_0002, rs2 = 0xABCD, awready delayed 3 cycles and wready immediate: wstrb = 4'b1100, wdata = 0xABCD_ABCD. wvalid drops after 1 cycle, awvalid after 3. DONE follows bvalid.
- LW with rresp = 2'b10: o_lsu_fault = 1. The fault clears on the next accepted instruction.
- With LSU_MISALIGN_CHECK_EN, SW at 0x8000_0001: no awvalid, fault = 1 at cycle 1. Without the macro: wstrb = 4'hF and a normal write.
- Assert rst in cycle 2 of a load with arready low: arvalid = 0 and o_pre_ready = 1 on the next cycle. A subsequent instruction completes normally.
